// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and helpers for the binary dense classifier.
//               Provides the FSM state type, size-derivation helpers and the
//               last-chunk validity mask generator.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest CHUNK the mask helper can describe.
  localparam int MASK_MAX = 1024;

  function automatic int calc_feat(input int in_ch, input int in_size);
    return in_ch * in_size * in_size;
  endfunction

  function automatic int calc_nchunk(input int feat, input int chunk);
    return (feat + chunk - 1) / chunk;
  endfunction

  function automatic int calc_score_w(input int feat);
    return $clog2(feat + 1);
  endfunction

  function automatic int calc_cls_w(input int num_classes);
    return (num_classes > 1) ? $clog2(num_classes) : 1;
  endfunction

  // Default-configuration sizes (8 maps of 14x14, 10 classes, 64-bit chunks).
  localparam int c_FEAT_DEF    = calc_feat(8, 14);
  localparam int c_NCHUNK_DEF  = calc_nchunk(c_FEAT_DEF, 64);
  localparam int c_SCORE_W_DEF = calc_score_w(c_FEAT_DEF);
  localparam int c_CLS_W_DEF   = calc_cls_w(10);

  // Ones in the positions of the final chunk that hold real feature bits;
  // callers keep the low CHUNK bits.
  function automatic logic [MASK_MAX-1:0] last_chunk_mask(input int feat, input int chunk);
    logic [MASK_MAX-1:0] m;
    int valid;
    valid = feat - (calc_nchunk(feat, chunk) - 1) * chunk;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) begin
      if (i < valid) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// ============================================================================
// Module      : popcount_chunk
// Description : Combinational population count of one CHUNK-bit slice.
// Ports       : i_bits  - bits to count
//               o_count - number of ones in i_bits
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_chunk #(
  parameter  int CHUNK = 64,
  localparam int PC_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] i_bits,
  output logic [PC_W-1:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + PC_W'(i_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_argmax.sv
`default_nettype none
// ============================================================================
// Module      : dense_argmax
// Description : Binary fully-connected classifier. Snapshots the pooled
//               feature maps, scores every class by XNOR-popcount against its
//               binary weight vector CHUNK bits per cycle, and reports the
//               argmax class and score with a level-style ready.
// Ports       : clk, rst_n       - clock, async active-low reset
//               data_in_ready    - upstream maps valid (level)
//               img_in[c]        - pooled binary map c
//               weights[k]       - binary weights of class k
//               class_out        - winning class index
//               score_out        - winning class popcount
//               data_out_ready   - class_out/score_out valid (level)
// Revision    : 1.0 - initial release
// ============================================================================
module dense_argmax
  import bnn_pkg::*;
#(
  parameter  int IN_CH       = 8,
  parameter  int IN_SIZE     = 14,
  parameter  int NUM_CLASSES = 10,
  parameter  int CHUNK       = 64,
  localparam int FEAT        = calc_feat(IN_CH, IN_SIZE),
  localparam int SCORE_W     = calc_score_w(FEAT),
  localparam int CLS_W       = calc_cls_w(NUM_CLASSES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_in_ready,
  input  logic [IN_SIZE*IN_SIZE-1:0] img_in  [0:IN_CH-1],
  input  logic [FEAT-1:0]            weights [0:NUM_CLASSES-1],
  output logic [CLS_W-1:0]           class_out,
  output logic [SCORE_W-1:0]         score_out,
  output logic                       data_out_ready
);

  localparam int c_PIX    = IN_SIZE * IN_SIZE;
  localparam int c_NCHUNK = calc_nchunk(FEAT, CHUNK);
  localparam int c_PADW   = c_NCHUNK * CHUNK;
  localparam int c_CHK_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam int c_PC_W   = $clog2(CHUNK + 1);

  localparam logic [MASK_MAX-1:0] c_MASK_FULL  = last_chunk_mask(FEAT, CHUNK);
  localparam logic [CHUNK-1:0]    c_LAST_MASK  = c_MASK_FULL[CHUNK-1:0];
  localparam logic [c_CHK_W-1:0]  c_LAST_CHUNK = c_CHK_W'(c_NCHUNK - 1);
  localparam logic [CLS_W-1:0]    c_LAST_CLS   = CLS_W'(NUM_CLASSES - 1);

  state_t               r_state, w_next_state;
  logic [FEAT-1:0]      r_feat;
  logic [CLS_W-1:0]     r_cls_cnt;
  logic [c_CHK_W-1:0]   r_chunk_cnt;
  logic [SCORE_W-1:0]   r_acc;
  logic [SCORE_W-1:0]   r_best_score;
  logic [CLS_W-1:0]     r_best_cls;

  logic [FEAT-1:0]      w_img_flat;
  logic [c_PADW-1:0]    w_feat_pad, w_wgt_pad;
  logic [CHUNK-1:0]     w_feat_chunk, w_wgt_chunk, w_mask, w_bits;
  logic [c_PC_W-1:0]    w_term;
  logic [SCORE_W-1:0]   w_total, w_best_score_nxt;
  logic [CLS_W-1:0]     w_best_cls_nxt;
  logic                 w_last_chunk, w_last_cls, w_better;
  logic                 w_capture, w_step, w_finish;

  // Feature bit f = c*IN_SIZE*IN_SIZE + p.
  generate
    for (genvar c = 0; c < IN_CH; c++) begin : g_flat
      assign w_img_flat[c*c_PIX +: c_PIX] = img_in[c];
    end
  endgenerate

  // Zero-pad to a whole number of chunks so the last part-select stays in
  // range; the padding is masked off before counting anyway.
  assign w_feat_pad   = c_PADW'(r_feat);
  assign w_wgt_pad    = c_PADW'(weights[r_cls_cnt]);
  assign w_feat_chunk = w_feat_pad[r_chunk_cnt*CHUNK +: CHUNK];
  assign w_wgt_chunk  = w_wgt_pad[r_chunk_cnt*CHUNK +: CHUNK];

  assign w_last_chunk = (r_chunk_cnt == c_LAST_CHUNK);
  assign w_last_cls   = (r_cls_cnt == c_LAST_CLS);
  assign w_mask       = w_last_chunk ? c_LAST_MASK : {CHUNK{1'b1}};
  assign w_bits       = ~(w_feat_chunk ^ w_wgt_chunk) & w_mask;

  popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
    .i_bits  (w_bits),
    .o_count (w_term)
  );

  assign w_total = r_acc + SCORE_W'(w_term);

  // Strict greater-than keeps the lower index on ties; class 0 always loads
  // so the running best starts from a real score.
  assign w_better         = (w_total > r_best_score) || (r_cls_cnt == '0);
  assign w_best_score_nxt = w_better ? w_total   : r_best_score;
  assign w_best_cls_nxt   = w_better ? r_cls_cnt : r_best_cls;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (data_in_ready) w_next_state = ACCUM;
      ACCUM: begin
        if (!data_in_ready)                  w_next_state = IDLE;
        else if (w_last_chunk && w_last_cls) w_next_state = DONE;
      end
      DONE:    if (!data_in_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    w_capture      = (r_state == IDLE)  && data_in_ready;
    w_step         = (r_state == ACCUM) && data_in_ready;
    w_finish       = w_step && w_last_chunk && w_last_cls;
    data_out_ready = (r_state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat       <= '0;
      r_cls_cnt    <= '0;
      r_chunk_cnt  <= '0;
      r_acc        <= '0;
      r_best_score <= '0;
      r_best_cls   <= '0;
      class_out    <= '0;
      score_out    <= '0;
    end else if (w_capture) begin
      r_feat       <= w_img_flat;
      r_cls_cnt    <= '0;
      r_chunk_cnt  <= '0;
      r_acc        <= '0;
      r_best_score <= '0;
      r_best_cls   <= '0;
    end else if (w_step) begin
      if (w_last_chunk) begin
        r_best_score <= w_best_score_nxt;
        r_best_cls   <= w_best_cls_nxt;
        r_acc        <= '0;
        r_chunk_cnt  <= '0;
        // Wrap the class counter after the final class so the weight
        // select never points past the array while idle.
        r_cls_cnt    <= w_finish ? '0 : r_cls_cnt + 1'b1;
        if (w_finish) begin
          class_out <= w_best_cls_nxt;
          score_out <= w_best_score_nxt;
        end
      end else begin
        r_acc       <= w_total;
        r_chunk_cnt <= r_chunk_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_argmax
// Description : Scoreboard bench for dense_argmax. Stimulus pushes the
//               hand-computed class/score/rise-edge of each run; a monitor
//               pops and compares on every data_out_ready rising level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_argmax;

  localparam int IN_CH       = 8;
  localparam int IN_SIZE     = 14;
  localparam int NUM_CLASSES = 10;
  localparam int CHUNK       = 64;
  localparam int PIX         = IN_SIZE * IN_SIZE;
  localparam int FEAT        = 1568;
  localparam int LAT         = 250;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data_in_ready = 1'b0;
  logic [PIX-1:0]   img_in  [0:IN_CH-1];
  logic [FEAT-1:0]  weights [0:NUM_CLASSES-1];
  logic [3:0]       class_out;
  logic [10:0]      score_out;
  logic             data_out_ready;

  dense_argmax #(
    .IN_CH       (IN_CH),
    .IN_SIZE     (IN_SIZE),
    .NUM_CLASSES (NUM_CLASSES),
    .CHUNK       (CHUNK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_ready  (data_in_ready),
    .img_in         (img_in),
    .weights        (weights),
    .class_out      (class_out),
    .score_out      (score_out),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cls;
    int score;
    int rise;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per rising data_out_ready.
  logic prev_dor = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (data_out_ready === 1'b1 && prev_dor !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: data_out_ready rose with nothing pending (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("class_out", 32'(class_out), 32'(e.cls));
        check("score_out", 32'(score_out), 32'(e.score));
        check("ready_rise_edge", 32'(cyc), 32'(e.rise));
      end
    end
    prev_dor = data_out_ready;
  end

  task automatic set_img(input logic v);
    for (int c = 0; c < IN_CH; c++) img_in[c] = {PIX{v}};
  endtask

  task automatic set_all_w(input logic v);
    for (int k = 0; k < NUM_CLASSES; k++) weights[k] = {FEAT{v}};
  endtask

  task automatic lower_ones(input int k, input int n);
    weights[k] = '0;
    for (int i = 0; i < n; i++) weights[k][i] = 1'b1;
  endtask

  // Raise data_in_ready; the following posedge is the capture edge E0.
  task automatic start_run(input int cls, input int score);
    exp_t e;
    @(negedge clk);
    data_in_ready = 1'b1;
    e.cls   = cls;
    e.score = score;
    e.rise  = cyc + 1 + LAT;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (data_out_ready !== 1'b1 && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    if (data_out_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: data_out_ready still %0b after %0d cycles", name, data_out_ready, n);
    end
  endtask

  // Hold DONE for 20 cycles while scrambling img_in, then release.
  task automatic finish_run(input int cls, input int score);
    repeat (20) begin
      @(negedge clk);
      for (int c = 0; c < IN_CH; c++)
        for (int b = 0; b < PIX; b++) img_in[c][b] = 1'($urandom_range(0, 1));
    end
    #1;
    check("hold_class", 32'(class_out), 32'(cls));
    check("hold_score", 32'(score_out), 32'(score));
    check("hold_ready", 32'(data_out_ready), 32'd1);
    @(negedge clk);
    data_in_ready = 1'b0;
    @(negedge clk);
    check("ready_fall", 32'(data_out_ready), 32'd0);
    check("class_kept", 32'(class_out), 32'(cls));
  endtask

  task automatic full_run(input string name, input int cls, input int score);
    start_run(cls, score);
    wait_done(name);
    finish_run(cls, score);
  endtask

  initial begin
    set_img(1'b0);
    set_all_w(1'b1);
    repeat (3) @(negedge clk);
    check("reset_class", 32'(class_out), 32'd0);
    check("reset_score", 32'(score_out), 32'd0);
    check("reset_ready", 32'(data_out_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero image; only class 3 (all-zero weights) matches every bit.
    set_img(1'b0);
    set_all_w(1'b1);
    weights[3] = '0;
    full_run("zero_img", 3, 1568);

    // Identical weights: tie across all classes keeps class 0.
    // Map 0 all ones, rest zero, weights zero -> 1568-196 matches.
    set_img(1'b0);
    img_in[0] = {PIX{1'b1}};
    set_all_w(1'b0);
    full_run("tie_all", 0, 1372);

    // All-ones image; padding must not lift the score past 1568.
    set_img(1'b1);
    for (int k = 0; k < NUM_CLASSES; k++) begin
      for (int i = 0; i < FEAT; i++) weights[k][i] = 1'($urandom_range(0, 1));
      weights[k][0] = 1'b0;
    end
    weights[7] = {FEAT{1'b1}};
    full_run("ones_img", 7, 1568);

    // Graded weights: classes 2 and 5 tie at 1518, class 8 at 1508.
    set_img(1'b0);
    for (int k = 0; k < NUM_CLASSES; k++) lower_ones(k, 1000);
    lower_ones(2, 50);
    lower_ones(5, 50);
    lower_ones(8, 60);
    full_run("graded", 2, 1518);

    // Abort 100 cycles into ACCUM; nothing may be reported.
    set_img(1'b0);
    set_all_w(1'b1);
    weights[3] = '0;
    @(negedge clk);
    data_in_ready = 1'b1;
    repeat (100) @(negedge clk);
    data_in_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_ready", 32'(data_out_ready), 32'd0);
    end
    full_run("after_abort", 3, 1568);

    // Reset pulse mid-ACCUM clears outputs immediately.
    @(negedge clk);
    data_in_ready = 1'b1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_class", 32'(class_out), 32'd0);
    check("midrst_score", 32'(score_out), 32'd0);
    check("midrst_ready", 32'(data_out_ready), 32'd0);
    data_in_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_ready", 32'(data_out_ready), 32'd0);

    // Last class differs only in the last valid feature bit.
    set_img(1'b0);
    set_all_w(1'b1);
    weights[9][FEAT-1] = 1'b0;
    full_run("last_bit", 9, 1);

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d results never seen", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
